instr_queue_reg: RTL and testbench

Parametrised instruction register with an integrated prefetch queue for the 8-bit CPU datapath. It accepts fetched instruction words over a valid/ready handshake and buffers up to DEPTH of them. It presents the oldest word in an output instruction register, with decoded fields, to the control unit and register file. It supports a synchronous flush for taken jumps and replaces the purely combinational instruction field splitter.

---
 rtl/instr_queue_reg.sv | 142 ++++++++++++++
 tb/tb_instr_queue_reg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_reg.sv
// ---------------------------------------------------------------------------
// instr_queue_reg
//
// Instruction register with an integrated prefetch queue for the 8-bit CPU
// datapath. Fetched words arrive over a valid/ready handshake and are held
// in a circular buffer of DEPTH entries. The oldest word is moved into the
// output instruction register (ir), whose contents are also split into the
// decoded fields used by the control unit and the register file.
//
// Optional feature (macro INSTR_REG_BYPASS_EN):
//   When defined, a word pushed while the queue is empty and ir is free goes
//   straight into ir at the same edge, which gives 1-cycle latency. When the
//   macro is undefined, every word passes through the queue (2-cycle latency).
//
// Parameters:
//   INSTR_W  instruction width in bits (>= 8)
//   DEPTH    queue entries, not counting ir (power of two, >= 2)
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_valid   fetch offers in_instr this cycle
//   in_instr   fetched instruction word
//   in_ready   queue can accept (low while flushing or full)
//   flush      synchronous discard of queued and held instructions
//   dec_ready  control unit consumes ir this cycle
//   dec_valid  ir holds a valid instruction
//   dec_instr  raw ir contents
//   opcode, jump_op, rs, rt, i_imm, j_imm, funct  decoded slices of ir
//   count      occupied queue entries (ir not included)
// ---------------------------------------------------------------------------
module instr_queue_reg #(
    parameter int INSTR_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [INSTR_W-1:0]       dec_instr,
    output logic [2:0]               opcode,
    output logic [1:0]               jump_op,
    output logic [1:0]               rs,
    output logic [1:0]               rt,
    output logic [1:0]               i_imm,
    output logic [INSTR_W-4:0]       j_imm,
    output logic                     funct,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [INSTR_W-1:0] ir;

    logic q_empty;
    logic ir_free;
    logic push;
    logic load;
    logic bypass;
    logic q_write;

    assign q_empty  = (count == '0);
    assign ir_free  = !dec_valid || dec_ready;
    assign in_ready = !flush && (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;

    // Loads only look at words already stored, so a word pushed this cycle
    // can reach ir no earlier than the following edge (unless bypassed).
    assign load = ir_free && !q_empty && !flush;

`ifdef INSTR_REG_BYPASS_EN
    // push already implies !flush, so flush still overrides the bypass.
    assign bypass = push && q_empty && ir_free;
`else
    assign bypass = 1'b0;
`endif

    assign q_write = push && !bypass;

    // Storage array has no reset: its contents only matter once count
    // says an entry is occupied.
    always_ff @(posedge clk) begin
        if (q_write) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dec_valid <= 1'b0;
            ir        <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dec_valid <= 1'b0;
        end else begin
            if (q_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (load) begin
                ir        <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
                dec_valid <= 1'b1;
            end else if (bypass) begin
                ir        <= in_instr;
                dec_valid <= 1'b1;
            end else if (dec_valid && dec_ready) begin
                dec_valid <= 1'b0;
            end

            case ({q_write, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dec_instr = ir;
    assign opcode    = ir[INSTR_W-1:INSTR_W-3];
    assign jump_op   = ir[INSTR_W-1:INSTR_W-2];
    assign rs        = ir[INSTR_W-4:INSTR_W-5];
    assign rt        = ir[INSTR_W-6:INSTR_W-7];
    assign i_imm     = ir[1:0];
    assign j_imm     = ir[INSTR_W-4:0];
    assign funct     = ir[0];

endmodule

// File: tb/tb_instr_queue_reg.sv
// ---------------------------------------------------------------------------
// tb_instr_queue_reg
//
// Self-checking bench for instr_queue_reg. A queue-based model tracks the
// stored words, the output register and its valid flag; a compare process
// checks every DUT output against the model on each falling edge. Directed
// sections pin the model with literal expectations, followed by a random
// phase driven by $urandom.
// ---------------------------------------------------------------------------
module tb_instr_queue_reg;

    localparam int INSTR_W = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               flush;
    logic               dec_ready;
    logic               dec_valid;
    logic [INSTR_W-1:0] dec_instr;
    logic [2:0]         opcode;
    logic [1:0]         jump_op;
    logic [1:0]         rs;
    logic [1:0]         rt;
    logic [1:0]         i_imm;
    logic [INSTR_W-4:0] j_imm;
    logic               funct;
    logic [CNT_W-1:0]   count;

    int total = 0;
    int bad   = 0;
    bit checkEn   = 1'b0;
    bit collectEn = 1'b0;

    logic [INSTR_W-1:0] modelQ[$];
    logic [INSTR_W-1:0] modelIr    = '0;
    bit                 modelValid = 1'b0;
    logic [INSTR_W-1:0] outQ[$];

    instr_queue_reg #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .dec_ready (dec_ready),
        .dec_valid (dec_valid),
        .dec_instr (dec_instr),
        .opcode    (opcode),
        .jump_op   (jump_op),
        .rs        (rs),
        .rt        (rt),
        .i_imm     (i_imm),
        .j_imm     (j_imm),
        .funct     (funct),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [INSTR_W-1:0] instr,
                                 input bit dr, input bit fl);
        in_valid  = v;
        in_instr  = instr;
        dec_ready = dr;
        flush     = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // Reference behaviour: a plain word queue plus the output register.
    task automatic modelStep();
        bit acc;
        bit free;
        acc  = in_valid && !flush && (modelQ.size() != DEPTH);
        free = !modelValid || dec_ready;
        if (flush) begin
            modelQ.delete();
            modelValid = 1'b0;
        end else begin
`ifdef INSTR_REG_BYPASS_EN
            if (acc && modelQ.size() == 0 && free) begin
                modelIr    = in_instr;
                modelValid = 1'b1;
                acc        = 1'b0;
            end else
`endif
            if (free) begin
                if (modelQ.size() > 0) begin
                    modelIr    = modelQ.pop_front();
                    modelValid = 1'b1;
                end else begin
                    modelValid = 1'b0;
                end
            end
            if (acc) modelQ.push_back(in_instr);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            modelIr    = '0;
            modelValid = 1'b0;
        end else begin
            modelStep();
        end
    end

    // Compare process: every output against the model, away from the edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("dec_valid", 32'(dec_valid), 32'(modelValid));
            checkOutput("count",     32'(count),     32'(modelQ.size()));
            checkOutput("in_ready",  32'(in_ready),  32'(!flush && modelQ.size() != DEPTH));
            checkOutput("dec_instr", 32'(dec_instr), 32'(modelIr));
            checkOutput("opcode",    32'(opcode),    32'(modelIr) >> 5);
            checkOutput("jump_op",   32'(jump_op),   32'(modelIr) >> 6);
            checkOutput("rs",        32'(rs),        (32'(modelIr) >> 3) & 3);
            checkOutput("rt",        32'(rt),        (32'(modelIr) >> 1) & 3);
            checkOutput("i_imm",     32'(i_imm),     32'(modelIr) & 3);
            checkOutput("j_imm",     32'(j_imm),     32'(modelIr) & 31);
            checkOutput("funct",     32'(funct),     32'(modelIr) & 1);
        end
    end

    always @(negedge clk) begin
        if (collectEn && dec_valid && dec_ready) outQ.push_back(dec_instr);
    end

    initial begin
        logic [INSTR_W-1:0] words[12];
        logic [INSTR_W-1:0] fillWords[5];
        int idx;
        bit accepted;

        fillWords = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset held with in_valid high.
        rst_n = 1'b0;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (3) begin
            cycle();
            checkEn = 1'b1;
            checkOutput("rst_dec_valid", 32'(dec_valid), 32'd0);
            checkOutput("rst_count",     32'(count),     32'd0);
            checkOutput("rst_opcode",    32'(opcode),    32'd0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        cycle();

        // Single word.
        applyStimulus(1'b1, 8'b0001_0000, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef INSTR_REG_BYPASS_EN
        checkOutput("single_not_yet_valid", 32'(dec_valid), 32'd0);
        checkOutput("single_count_1",       32'(count),     32'd1);
        cycle();
`endif
        checkOutput("single_valid",  32'(dec_valid), 32'd1);
        checkOutput("single_opcode", 32'(opcode),    32'b000);
        checkOutput("single_rs",     32'(rs),        32'b10);
        checkOutput("single_rt",     32'(rt),        32'b00);
        checkOutput("single_funct",  32'(funct),     32'd0);
        checkOutput("single_j_imm",  32'(j_imm),     32'b10000);
        checkOutput("single_i_imm",  32'(i_imm),     32'b00);
        cycle();
        checkOutput("single_drained", 32'(dec_valid), 32'd0);

        // Fill and stall, then drain in order.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, fillWords[k], 1'b0, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("fill_ir",       32'(dec_instr), 32'h11);
        checkOutput("fill_count",    32'(count),     32'd4);
        checkOutput("fill_in_ready", 32'(in_ready),  32'd0);
        dec_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("drain_valid", 32'(dec_valid), 32'd1);
            checkOutput("drain_word",  32'(dec_instr), 32'(fillWords[k]));
            cycle();
        end
        checkOutput("drain_empty", 32'(dec_valid), 32'd0);

        // Wrap-around with random backpressure.
        for (int k = 0; k < 12; k++) words[k] = INSTR_W'($urandom);
        outQ.delete();
        collectEn = 1'b1;
        idx = 0;
        for (int c = 0; c < 200 && idx < 12; c++) begin
            applyStimulus(1'b1, words[idx], 1'($urandom_range(0, 1)), 1'b0);
            #1;
            accepted = in_ready;
            checkOutput("wrap_count_max", 32'(count <= DEPTH), 32'd1);
            cycle();
            if (accepted) idx++;
        end
        checkOutput("wrap_all_pushed", 32'(idx), 32'd12);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (8) cycle();
        collectEn = 1'b0;
        checkOutput("wrap_out_count", 32'(outQ.size()), 32'd12);
        for (int k = 0; k < 12 && k < outQ.size(); k++) begin
            checkOutput("wrap_order", 32'(outQ[k]), 32'(words[k]));
        end

        // Flush with three queued words and ir valid.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 8'hA1 + 8'(k), 1'b0, 1'b0);
            cycle();
        end
        checkOutput("pre_flush_count", 32'(count),     32'd3);
        checkOutput("pre_flush_valid", 32'(dec_valid), 32'd1);
        checkOutput("pre_flush_ir",    32'(dec_instr), 32'hA1);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
        #1;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        cycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_valid", 32'(dec_valid), 32'd0);
        checkOutput("flush_count", 32'(count),     32'd0);
        repeat (3) begin
            cycle();
            checkOutput("flush_no_ghost", 32'(dec_valid), 32'd0);
        end

        // Asynchronous reset between edges.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'hB1 + 8'(k), 1'b0, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("pre_areset_count", 32'(count), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_valid", 32'(dec_valid), 32'd0);
        checkOutput("areset_count", 32'(count),     32'd0);
        checkOutput("areset_ir",    32'(dec_instr), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Random phase checked by the model.
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, INSTR_W'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            cycle();
        end

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
